// File: rtl/inst_fetch_pkg.sv
// Shared ISA constants, fault-cause encodings and types for the instruction fetch stage.
package inst_fetch_pkg;

  localparam int                   ISA__XLEN         = 32;
  localparam logic [ISA__XLEN-1:0] ISA__RESET_VECTOR = 32'h0000_0000;

  localparam logic ISA__CAUSE_MISALIGNED = 1'b0;
  localparam logic ISA__CAUSE_ACCESS     = 1'b1;

  typedef enum logic [1:0] {
    ST_START,
    ST_FETCH,
    ST_FLUSH,
    ST_FAULT
  } fetch_state_e;

  typedef struct packed {
    logic [ISA__XLEN-1:0] inst;
    logic [ISA__XLEN-1:0] pc;
    logic                 fault;
    logic                 cause;
  } fetch_entry_t;

  function automatic logic is_misaligned(input logic [1:0] pc_lsb);
    return pc_lsb != 2'b00;
  endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// Instruction memory bus, redirect input and decode-side output of the fetch stage.
interface inst_fetch_if;
  import inst_fetch_pkg::*;

  // A transfer happens on a rising edge where valid (mem_req / inst_valid) and ready
  // (mem_ack / inst_ready) are both high; mem_req holds mem_addr stable until mem_ack,
  // while inst_valid is withdrawn without a transfer only by a redirect flush.
  logic                 mem_req;
  logic [ISA__XLEN-1:0] mem_addr;
  logic                 mem_ack;
  logic [ISA__XLEN-1:0] mem_rdata;
  logic                 mem_err;

  logic                 redirect;
  logic [ISA__XLEN-1:0] redirect_pc;

  logic                 inst_valid;
  logic                 inst_ready;
  logic [ISA__XLEN-1:0] inst;
  logic [ISA__XLEN-1:0] inst_pc;
  logic                 fetch_fault;
  logic                 fault_cause;

  modport master (
    output mem_req, mem_addr,
    input  mem_ack, mem_rdata, mem_err,
    input  redirect, redirect_pc,
    output inst_valid, inst, inst_pc, fetch_fault, fault_cause,
    input  inst_ready
  );

  modport slave (
    input  mem_req, mem_addr,
    output mem_ack, mem_rdata, mem_err,
    output redirect, redirect_pc,
    input  inst_valid, inst, inst_pc, fetch_fault, fault_cause,
    output inst_ready
  );

endinterface

// File: rtl/inst_fetch_buffer.sv
// Two-entry FIFO between the fetch bus and decode; slot0 is always the head.
module fetch_buffer
  import inst_fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  fetch_entry_t push_entry_i,
  input  logic         pop_i,
  input  logic         flush_i,
  output fetch_entry_t head_o,
  output logic [1:0]   count_o
);

  fetch_entry_t slot0_q, slot0_d;
  fetch_entry_t slot1_q, slot1_d;
  logic [1:0]   count_q, count_d;

  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    count_d = count_q;
    if (flush_i) begin
      // A flush may carry a single replacement entry (misaligned-redirect fault).
      count_d = {1'b0, push_i};
      if (push_i) slot0_d = push_entry_i;
    end else begin
      case ({push_i, pop_i})
        2'b10: begin
          if (count_q == 2'd0) slot0_d = push_entry_i;
          else                 slot1_d = push_entry_i;
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          slot0_d = slot1_q;
          count_d = count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            slot0_d = push_entry_i;
          end else begin
            slot0_d = slot1_q;
            slot1_d = push_entry_i;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot0_q <= '0;
      slot1_q <= '0;
      count_q <= 2'd0;
    end else begin
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      count_q <= count_d;
    end
  end

  assign head_o  = slot0_q;
  assign count_o = count_q;

endmodule

// File: rtl/inst_fetch.sv
// Fetch stage: PC generation, single-outstanding instruction reads, redirect squashing
// and in-band fault reporting into a two-entry output buffer.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [ISA__XLEN-1:0] RESET_VECTOR = ISA__RESET_VECTOR
) (
  input  logic         clk,
  input  logic         rst,
  inst_fetch_if.master bus,
  output fetch_state_e state_o
);

  fetch_state_e         state_q, state_d;
  logic [ISA__XLEN-1:0] pc_q, pc_d;
  logic [ISA__XLEN-1:0] mem_addr_q, mem_addr_d;
  logic                 mem_req_q, mem_req_d;

  logic                 ack;
  logic                 pending;
  logic                 pop;
  logic                 push;
  logic                 flush;
  fetch_entry_t         push_entry;
  fetch_entry_t         head;
  logic [1:0]           count;
  logic [2:0]           occ_after;

  assign ack     = mem_req_q & bus.mem_ack;
  assign pending = mem_req_q & ~bus.mem_ack;
  assign pop     = (count != 2'd0) & bus.inst_ready;
  // Occupancy after this edge when the only possible push is the bus ack.
  assign occ_after = {1'b0, count} - {2'b00, pop} + {2'b00, ack};

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    push       = 1'b0;
    push_entry = '0;
    flush      = 1'b0;
    if (bus.redirect) begin
      flush = 1'b1;
      pc_d  = bus.redirect_pc;
      if (is_misaligned(bus.redirect_pc[1:0])) begin
        push       = 1'b1;
        push_entry = '{inst: '0, pc: bus.redirect_pc, fault: 1'b1, cause: ISA__CAUSE_MISALIGNED};
        state_d    = ST_FAULT;
        mem_req_d  = pending;
      end else if (pending) begin
        state_d = ST_FLUSH;
      end else begin
        state_d    = ST_FETCH;
        mem_req_d  = 1'b1;
        mem_addr_d = bus.redirect_pc;
      end
    end else begin
      case (state_q)
        ST_START: begin
          state_d    = ST_FETCH;
          mem_req_d  = 1'b1;
          mem_addr_d = pc_q;
        end
        ST_FETCH: begin
          if (ack && bus.mem_err) begin
            push       = 1'b1;
            push_entry = '{inst: '0, pc: mem_addr_q, fault: 1'b1, cause: ISA__CAUSE_ACCESS};
            state_d    = ST_FAULT;
            mem_req_d  = 1'b0;
          end else if (!pending) begin
            if (ack) begin
              push       = 1'b1;
              push_entry = '{inst: bus.mem_rdata, pc: mem_addr_q, fault: 1'b0, cause: 1'b0};
              pc_d       = pc_q + ISA__XLEN'(4);
            end
            mem_req_d = occ_after < 3'd2;
            if (occ_after < 3'd2) mem_addr_d = pc_d;
          end
        end
        ST_FLUSH: begin
          // Wrong-path data is dropped; pc_q already holds the redirect target.
          if (ack) begin
            state_d    = ST_FETCH;
            mem_req_d  = 1'b1;
            mem_addr_d = pc_q;
          end
        end
        ST_FAULT: begin
          mem_req_d = pending;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_START;
      pc_q       <= RESET_VECTOR;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  fetch_buffer u_buffer (
    .clk          (clk),
    .rst          (rst),
    .push_i       (push),
    .push_entry_i (push_entry),
    .pop_i        (pop),
    .flush_i      (flush),
    .head_o       (head),
    .count_o      (count)
  );

  assign bus.mem_req     = mem_req_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.inst_valid  = count != 2'd0;
  assign bus.inst        = head.inst;
  assign bus.inst_pc     = head.pc;
  assign bus.fetch_fault = head.fault;
  assign bus.fault_cause = head.cause;
  assign state_o         = state_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Testbench for inst_fetch: reset/throughput/backpressure vectors, directed redirect and
// fault sequences, then random traffic against an instruction-stream scoreboard.
module tb_inst_fetch;
  import inst_fetch_pkg::*;

  localparam logic [31:0] RV = 32'h0000_0100;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  inst_fetch_if bus ();
  fetch_state_e state;

  inst_fetch #(.RESET_VECTOR(RV)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .state_o (state)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_deliv  = 0;
  bit err_en   = 1'b0;

  task automatic check(input string name, input logic [65:0] got, input logic [65:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // Memory contents and bus-error map, both pure functions of the word address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  function automatic bit is_err(input logic [31:0] a);
    return err_en && (a[6:2] == 5'h13);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input bit ack, input bit err, input bit ready,
                       input bit redir, input logic [31:0] rpc);
    bus.mem_ack     = ack;
    bus.mem_rdata   = ack ? mem_word(bus.mem_addr) : $urandom;
    bus.mem_err     = err;
    bus.inst_ready  = ready;
    bus.redirect    = redir;
    bus.redirect_pc = rpc;
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_entry(input string name, input logic [31:0] inst,
                             input logic [31:0] pc, input bit fault, input bit cause);
    check({name, "_valid"}, bus.inst_valid, 1'b1);
    check({name, "_entry"}, {bus.inst, bus.inst_pc, bus.fetch_fault, bus.fault_cause},
          {inst, pc, fault, cause});
  endtask

  // ---------------- scoreboard ----------------
  // Expected delivered stream: sequential words from the last redirect/reset target,
  // ending after the first access fault; a misaligned target yields one fault entry only.
  logic [65:0] exp_q[$];
  logic [31:0] gen_pc;
  bit          gen_live;

  task automatic sb_restart(input logic [31:0] pc);
    exp_q.delete();
    if (pc[1:0] != 2'b00) begin
      exp_q.push_back({32'h0, pc, 1'b1, 1'b0});
      gen_live = 1'b0;
    end else begin
      gen_pc   = pc;
      gen_live = 1'b1;
    end
  endtask

  task automatic sb_topup;
    while (gen_live && exp_q.size() < 4) begin
      if (is_err(gen_pc)) begin
        exp_q.push_back({32'h0, gen_pc, 1'b1, 1'b1});
        gen_live = 1'b0;
      end else begin
        exp_q.push_back({mem_word(gen_pc), gen_pc, 1'b0, 1'b0});
      end
      gen_pc = gen_pc + 32'd4;
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct packed {
    bit          skip;
    bit          rst_v;
    bit          ack;
    bit          ready;
    bit          chk_rst;
    bit          exp_req;
    logic [31:0] exp_addr;
    bit          exp_valid;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[14];

  function automatic vec_t mk(bit skip, bit rst_v, bit ack, bit ready, bit chk_rst,
                              bit req, logic [31:0] addr, bit valid, logic [31:0] pc);
    vec_t v;
    v.skip = skip; v.rst_v = rst_v; v.ack = ack; v.ready = ready; v.chk_rst = chk_rst;
    v.exp_req = req; v.exp_addr = addr; v.exp_valid = valid; v.exp_pc = pc;
    return v;
  endfunction

  logic [31:0] pend_addr;
  bit          pend;
  int unsigned delay;
  bit          r_ack, r_err, r_ready, r_redir;
  logic [31:0] r_pc;

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);

    // Outputs sampled at each negedge are the result of earlier rows' inputs.
    vecs[0]  = mk(1, 1, 0, 1, 0, 0, 32'h0,   0, 32'h0);
    vecs[1]  = mk(0, 0, 1, 1, 1, 0, 32'h0,   0, 32'h0);
    vecs[2]  = mk(0, 0, 1, 1, 0, 1, 32'h100, 0, 32'h0);
    vecs[3]  = mk(0, 0, 1, 1, 0, 1, 32'h104, 1, 32'h100);
    vecs[4]  = mk(0, 0, 1, 1, 0, 1, 32'h108, 1, 32'h104);
    vecs[5]  = mk(0, 0, 1, 1, 0, 1, 32'h10C, 1, 32'h108);
    vecs[6]  = mk(0, 1, 1, 1, 0, 1, 32'h110, 1, 32'h10C);
    vecs[7]  = mk(0, 0, 1, 0, 1, 0, 32'h0,   0, 32'h0);
    vecs[8]  = mk(0, 0, 1, 0, 0, 1, 32'h100, 0, 32'h0);
    vecs[9]  = mk(0, 0, 1, 0, 0, 1, 32'h104, 1, 32'h100);
    vecs[10] = mk(0, 0, 1, 0, 0, 0, 32'h0,   1, 32'h100);
    vecs[11] = mk(0, 0, 1, 1, 0, 0, 32'h0,   1, 32'h100);
    vecs[12] = mk(0, 0, 1, 1, 0, 1, 32'h108, 1, 32'h104);
    vecs[13] = mk(0, 0, 1, 1, 0, 1, 32'h10C, 1, 32'h108);

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (!vecs[i].skip) begin
        check($sformatf("v%0d_req", i), bus.mem_req, vecs[i].exp_req);
        check($sformatf("v%0d_valid", i), bus.inst_valid, vecs[i].exp_valid);
        if (vecs[i].exp_req || vecs[i].chk_rst)
          check($sformatf("v%0d_addr", i), bus.mem_addr, vecs[i].exp_addr);
        if (vecs[i].exp_valid || vecs[i].chk_rst)
          check($sformatf("v%0d_pc", i), bus.inst_pc, vecs[i].exp_pc);
        if (vecs[i].exp_valid)
          check($sformatf("v%0d_inst", i), {bus.inst, bus.fetch_fault},
                {mem_word(vecs[i].exp_pc), 1'b0});
        if (vecs[i].chk_rst)
          check($sformatf("v%0d_rstout", i), {bus.inst, bus.fetch_fault, bus.fault_cause}, '0);
      end
      rst = vecs[i].rst_v;
      drive(vecs[i].ack, 1'b0, vecs[i].ready, 1'b0, 32'h0);
    end

    // Redirect to 0x200 while 0x104 is in flight; ack arrives three cycles later.
    do_reset();
    @(negedge clk); check("fl_addr0", {bus.mem_req, bus.mem_addr}, {1'b1, 32'h100});
    drive(1, 0, 1, 0, 32'h0);
    @(negedge clk); check("fl_addr1", {bus.mem_req, bus.mem_addr}, {1'b1, 32'h104});
    drive(0, 0, 1, 1, 32'h200);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("fl_hold%0d", k), {bus.mem_req, bus.mem_addr, bus.inst_valid},
            {1'b1, 32'h104, 1'b0});
      if (k == 0) check("fl_state", state, ST_FLUSH);
      if (k < 2) drive(0, 0, 1, 0, 32'h0);
      else begin drive(1, 0, 1, 0, 32'h0); bus.mem_rdata = 32'hBAD0_BAD0; end
    end
    @(negedge clk);
    check("fl_target", {bus.mem_req, bus.mem_addr, bus.inst_valid}, {1'b1, 32'h200, 1'b0});
    drive(1, 0, 1, 0, 32'h0);
    @(negedge clk); check_entry("fl_first", mem_word(32'h200), 32'h200, 0, 0);

    // Misaligned redirect: fault entry next cycle, no requests until a new redirect.
    do_reset();
    @(negedge clk);
    drive(1, 0, 0, 1, 32'h202);
    @(negedge clk);
    check_entry("mis_entry", 32'h0, 32'h202, 1, 0);
    check("mis_req", bus.mem_req, 1'b0);
    check("mis_state", state, ST_FAULT);
    drive(0, 0, 0, 0, 32'h0);
    @(negedge clk); check("mis_hold", {bus.mem_req, bus.inst_valid}, 2'b01);
    drive(0, 0, 1, 0, 32'h0);
    @(negedge clk); check("mis_idle0", {bus.mem_req, bus.inst_valid}, 2'b00);
    @(negedge clk); check("mis_idle1", bus.mem_req, 1'b0);
    drive(0, 0, 1, 1, 32'h300);
    @(negedge clk); check("mis_restart", {bus.mem_req, bus.mem_addr}, {1'b1, 32'h300});
    drive(1, 0, 1, 0, 32'h0);
    @(negedge clk); check_entry("mis_first", mem_word(32'h300), 32'h300, 0, 0);

    // Bus error on 0x104: access-fault entry, request line stays low until redirect.
    do_reset();
    @(negedge clk); drive(1, 0, 1, 0, 32'h0);
    @(negedge clk); drive(1, 1, 1, 0, 32'h0);
    @(negedge clk);
    check_entry("err_entry", 32'h0, 32'h104, 1, 1);
    check("err_req0", bus.mem_req, 1'b0);
    drive(0, 0, 0, 0, 32'h0);
    @(negedge clk); check("err_req1", bus.mem_req, 1'b0);
    @(negedge clk); check("err_req2", bus.mem_req, 1'b0);
    drive(0, 0, 0, 1, 32'h400);
    @(negedge clk);
    check("err_restart", {bus.mem_req, bus.mem_addr, bus.inst_valid}, {1'b1, 32'h400, 1'b0});

    // Asynchronous reset with a request outstanding and an entry buffered.
    do_reset();
    @(negedge clk); drive(1, 0, 1, 0, 32'h0);
    @(negedge clk); drive(0, 0, 0, 0, 32'h0);
    @(negedge clk);
    check("ar_before", {bus.mem_req, bus.inst_valid}, 2'b11);
    rst = 1'b1;
    #1;
    check("ar_outputs", {bus.mem_req, bus.mem_addr, bus.inst_valid, bus.inst, bus.inst_pc,
                         bus.fetch_fault, bus.fault_cause}, '0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk); check("ar_first", {bus.mem_req, bus.mem_addr}, {1'b1, RV});

    // Random traffic: variable ack latency, bus errors, backpressure and redirects.
    do_reset();
    err_en = 1'b1;
    sb_restart(RV);
    pend = 1'b0;
    delay = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      if (pend) check("rnd_req_held", {bus.mem_req, bus.mem_addr}, {1'b1, pend_addr});
      r_ack = 1'b0;
      r_err = 1'($urandom_range(0, 1));
      if (bus.mem_req) begin
        if (!pend) begin
          pend      = 1'b1;
          pend_addr = bus.mem_addr;
          delay     = $urandom_range(0, 1) ? 0 : $urandom_range(1, 3);
        end
        if (delay == 0) begin
          r_ack = 1'b1;
          r_err = is_err(bus.mem_addr);
          pend  = 1'b0;
        end else begin
          delay--;
        end
      end
      r_ready = $urandom_range(0, 3) != 0;
      r_redir = $urandom_range(0, 39) == 0;
      r_pc    = $urandom & 32'h0000_0FFC;
      case ($urandom_range(0, 7))
        0: r_pc = r_pc | 32'h1;
        1: r_pc = 32'hFFFF_FFF0;
        default: ;
      endcase
      drive(r_ack, r_err, r_ready, r_redir, r_pc);
      if (bus.inst_valid && r_ready) begin
        sb_topup();
        n_deliv++;
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL rnd_extra: got entry pc %h, none expected", bus.inst_pc);
        end else begin
          check("rnd_entry", {bus.inst, bus.inst_pc, bus.fetch_fault, bus.fault_cause},
                exp_q.pop_front());
        end
      end
      if (r_redir) sb_restart(r_pc);
    end
    check("rnd_progress", n_deliv > 500, 1'b1);

    // ---------------- final report ----------------
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch stage of the core. Generates the program counter, issues single-outstanding word reads to the instruction memory bus, and presents fetched 32-bit instructions with their PC to `inst_decode` through a valid/ready handshake. Handles control-flow redirects from execute/trap logic, squashing wrong-path data, and reports misaligned and bus-error fetch faults in-band.

## Interface
- `RESET_VECTOR`, default 32'h0000_0000: PC fetched first after reset.
- `clk`  in  1  core clock, all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `mem_req`  out  1  read request, registered; held until `mem_ack`.
- `mem_addr`  out  `ISA__XLEN`  word address, registered; stable while `mem_req`.
- `mem_ack`  in  1  transfer completes in any cycle with `mem_req && mem_ack`; may be combinational.
- `mem_rdata`  in  `ISA__XLEN`  instruction word, valid with `mem_ack`.
- `mem_err`  in  1  bus fault, qualified by `mem_ack`.
- `redirect`  in  1  single-cycle pulse: restart fetch at `redirect_pc`.
- `redirect_pc`  in  `ISA__XLEN`  target PC.
- `inst_valid`  out  1  head entry available.
- `inst_ready`  in  1  decode accepts head entry.
- `inst`  out  `ISA__XLEN`  instruction word (32'h0 on fault).
- `inst_pc`  out  `ISA__XLEN`  PC of `inst`.
- `fetch_fault`  out  1  entry is a fault, not an instruction.
- `fault_cause`  out  1  0 = misaligned PC, 1 = access fault.

## Operation
- Reset values: `mem_req`=0, `mem_addr`=0, `inst_valid`=0, `inst`=0, `inst_pc`=0, `fetch_fault`=0, `fault_cause`=0; pc=`RESET_VECTOR`; state START; buffer empty.
- States: START -> FETCH unconditionally (first request the cycle after reset release). FETCH: issue/hold requests. FLUSH: redirect arrived with request in flight; keep `mem_req`/`mem_addr` unchanged until ack, drop data, then FETCH at saved target. FAULT: no requests; leave only on `redirect`.
- Output path is a 2-entry FIFO of {inst, pc, fault, cause}; head drives outputs; pop on `inst_valid && inst_ready`.
- Credit rule: next-cycle `mem_req`=1 only if buffer occupancy after this cycle's push/pop is <2 and state is FETCH with no fault pending.
- On good ack: push {mem_rdata, mem_addr, 0, 0}; pc <= pc+4 (mod 2^XLEN, wraps silently).
- On ack with `mem_err`: push {0, mem_addr, 1, 1}; enter FAULT.
- `redirect` has priority over all: flush buffer (`inst_valid`=0 next cycle, same-cycle pop still counts as handshake), any ack data this cycle discarded. If `redirect_pc[1:0]`!=0: push {0, redirect_pc, 1, 0}, enter FAULT, no bus request. Else if request in flight and not acked this cycle: FLUSH; else FETCH at `redirect_pc`.
- `redirect` in FLUSH overwrites saved target; `redirect` in FAULT restarts normally.
- Async `rst` mid-transfer: `mem_req` drops immediately; memory side must tolerate abandoned request.

## Timing
- Ack in cycle N -> entry at head in N+1 (if buffer was empty) and next `mem_req` in N+1 when credit allows.
- Sustained throughput one instruction/cycle with combinational ack and `inst_ready`=1.
- Redirect in cycle N -> `mem_addr`=`redirect_pc`, `mem_req`=1 in N+1 (no flight), or cycle after the pending ack (FLUSH).
- Misaligned redirect in N -> fault entry valid in N+1.
- Backpressure: at most 2 buffered entries, `mem_req` low while full.

## Structure
- Fault-cause encodings and `RESET_VECTOR` default go in `isa.svh` alongside existing `ISA__` constants.
- Sub-module `fetch_buffer`: 2-entry FIFO with push, pop, flush, count; same clk/rst.
- FSM, pc, credit logic in `inst_fetch`.

## Test plan
- `RESET_VECTOR`=0x100, combinational ack, `inst_ready`=1 -> `mem_addr` 0x100,0x104,0x108 on consecutive cycles; `inst_pc` same sequence one cycle later.
- `inst_ready`=0 from reset -> two entries (0x100,0x104) buffered, `mem_req` low; raise ready -> popped in order, fetch resumes at 0x108.
- Request 0x104 in flight, ack delayed 3 cycles, `redirect` to 0x200 -> `mem_addr` holds 0x104 until ack, data discarded, next request 0x200, no 0x104 entry ever valid.
- `redirect_pc`=0x202 -> no bus request, entry {pc 0x202, fault=1, cause=0}; idle until `redirect` 0x300 -> fetch at 0x300.
- `mem_err` on 0x104 -> entry {inst 0, pc 0x104, fault=1, cause=1}, `mem_req` stays low until redirect.
- Assert `rst` while `mem_req`=1 -> all outputs at reset values same cycle; after release first request at `RESET_VECTOR`.
